vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing for the display path.
- Drives the current pixel coordinates (DrawX, DrawY) to the object/colour logic and to color_mapper.
- Drives the sync and blank strobes to the DAC, delayed so they stay aligned with the colour-path latency.
- Runs on the 50 MHz system clock and derives the pixel rate with an internal clock-enable divider.

Parameters:
- PIX_DIV, 2: system clocks per pixel; legal range 1..4.
- PIPE_DLY, 1: pixel ticks of delay applied to HS/VS/BLANK_N/frame_start, matching the colour-path latency; legal range 0..3.
- H_VIS, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels; total 800.
- V_VIS, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines; total 525.

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous reset, active-low
- DrawX  out  10  horizontal pixel counter, 0..799
- DrawY  out  10  vertical line counter, 0..524
- pix_en  out  1  one-Clk-wide pixel-tick strobe
- VGA_CLK  out  1  pixel clock to DAC; 50% duty for even PIX_DIV
- VGA_HS  out  1  horizontal sync, active-low
- VGA_VS  out  1  vertical sync, active-low
- VGA_BLANK_N  out  1  high only in the visible region
- VGA_SYNC_N  out  1  tied 0 (no sync-on-green)
- frame_start  out  1  one-pixel-tick pulse at the start of each frame

Behaviour:
- Reset values (Reset_n low, asynchronous):
  - Divider count = 0; DrawX = 0; DrawY = 0.
  - VGA_HS = 1; VGA_VS = 1; VGA_BLANK_N = 0; frame_start = 0; pix_en = 0; VGA_CLK = 0.
  - All PIPE_DLY delay stages load these inactive values.
- Divider:
  - Counts 0..PIX_DIV-1 and wraps.
  - pix_en is high for the Clk cycle when the count equals PIX_DIV-1. For PIX_DIV=1, pix_en is constantly 1 after reset.
  - VGA_CLK is high while count >= PIX_DIV/2 (integer division). For PIX_DIV=1, VGA_CLK = pix_en gated high.
- Counters advance only on Clk edges where pix_en=1:
  - DrawX increments; at 799 it wraps to 0.
  - On that wrap, DrawY increments; at 524 it wraps to 0.
  - DrawX and DrawY are registered and not delayed. They are the address the colour pipeline consumes.
- Raw strobes, decoded combinationally from the counters:
  - hs_raw = 0 when 656 <= DrawX <= 751.
  - vs_raw = 0 when 490 <= DrawY <= 491.
  - blank_raw = 1 when DrawX < 640 and DrawY < 480.
  - fs_raw = 1 when DrawX = 0 and DrawY = 0.
- Output alignment:
  - Raw strobes pass through a PIPE_DLY-deep shift register clocked on pix_en, then drive the outputs.
  - With PIPE_DLY=0 the outputs are registered copies of the raw strobes, updated on the same edge as the counters.
  - Relative to the DrawX/DrawY values, outputs therefore lag by PIPE_DLY+1 pixel ticks less the counter register, which is the same 1-tick register as color_mapper's downstream registers. The bench checks the exact offsets stated in the Test Plan.
- frame_start: high for exactly one pix_en period per frame, i.e. the interval between consecutive pix_en edges.
- Mid-operation reset: everything returns immediately to the reset values. The first frame after release begins at DrawX=0, DrawY=0. No partial-line recovery is required.
- Parameter checks: illegal PIX_DIV or PIPE_DLY values are fatal at elaboration (generate-time $error).
- No handshake: the downstream colour logic must produce the colour for DrawX/DrawY within PIPE_DLY pixel ticks.

Decomposition:
- vga_pkg holds:
  - the H/V timing localparams;
  - derived constants: H_TOTAL=800, V_TOTAL=525, HS_START=656, HS_END=751, VS_START=490, VS_END=491;
  - typedef coord_t = logic [9:0].
- One sub-module, vga_sync_delay: a parameterised depth-N shift register with per-bit reset value and enable. It is reused later for sprite-pipeline alignment.

Test Plan:
- Reset and first ticks: hold Reset_n=0 for 5 Clk, release.
  - Required: all outputs at reset values during reset.
  - Required: pix_en first high on Clk 2 after release (PIX_DIV=2).
  - Required: DrawX goes 0→1 on the 1st pix_en edge.
- Line timing:
  - Required: DrawX wraps 799→0 every 1600 Clk.
  - Required: DrawY increments on that wrap.
  - Required: VGA_HS low for exactly 96 pixel ticks per line, falling PIPE_DLY+1 ticks after DrawX reaches 656.
- Frame timing:
  - Required: VGA_VS low for exactly 2 lines (1600 ticks), starting on line 490.
  - Required: frame period = 420000 pixel ticks.
  - Required: frame_start pulses once per frame, width 2 Clk.
- Blanking:
  - Required: VGA_BLANK_N high for 640 consecutive ticks per line on lines 0..479 and never high on lines 480..524.
  - Required: count of high ticks per frame = 307200.
- Mid-frame reset: assert Reset_n=0 at DrawX=300, DrawY=200, asynchronously between Clk edges.
  - Required: outputs reach reset values before the next Clk edge.
  - Required: after release, the counters restart from 0,0.
- Parameter sweep: PIX_DIV ∈ {1,2,4} × PIPE_DLY ∈ {0,3}.
  - Required: the 96-tick HS width holds in every combination.
  - Required: the HS falling edge lags DrawX=656 by PIPE_DLY+1 ticks in every combination.
  - Required: line period = 800·PIX_DIV Clk in every combination.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and types for the display path.
package vga_pkg;

  // Horizontal timing in pixels
  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  // Vertical timing in lines
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  // Derived raster constants
  localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;  // 525
  localparam int HS_START = H_VIS + H_FP;                  // 656
  localparam int HS_END   = HS_START + H_SYNC - 1;         // 751
  localparam int VS_START = V_VIS + V_FP;                  // 490
  localparam int VS_END   = VS_START + V_SYNC - 1;         // 491

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  // Strobe bundle carried through the alignment delay
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
    logic fs;
  } sync_t;

  // Value every strobe holds in reset and outside its active region
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, fs: 1'b0};

  // True when a raster dimension can be addressed by a coord_t counter
  function automatic bit fits_coord(input int total);
    return (total >= 1) && (total <= (1 << COORD_W));
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Depth-N enabled shift register with a per-bit reset value; used to align
// strobes with a fixed-latency data path.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int                 WIDTH   = 1,
  parameter int                 DEPTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH < 1) begin : g_chk_depth
    $error("vga_sync_delay: DEPTH=%0d must be at least 1", DEPTH);
  end

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per enable; every stage resets to RST_VAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= RST_VAL;
      end
    end else if (en) begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel clock-enable divider, DrawX/DrawY
// raster counters and sync/blank/frame strobes delayed to match the colour path.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int PIX_DIV  = 2,
  parameter int PIPE_DLY = 1,
  parameter int H_VIS    = vga_pkg::H_VIS,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_VIS    = vga_pkg::V_VIS,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pix_en,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       frame_start
);

  localparam int LINE_LEN    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST    = H_VIS + H_FP;
  localparam int HS_LAST     = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST    = V_VIS + V_FP;
  localparam int VS_LAST     = VS_FIRST + V_SYNC - 1;

  localparam coord_t X_LAST    = coord_t'(LINE_LEN - 1);
  localparam coord_t Y_LAST    = coord_t'(FRAME_LINES - 1);
  localparam coord_t X_HS_LO   = coord_t'(HS_FIRST);
  localparam coord_t X_HS_HI   = coord_t'(HS_LAST);
  localparam coord_t Y_VS_LO   = coord_t'(VS_FIRST);
  localparam coord_t Y_VS_HI   = coord_t'(VS_LAST);
  localparam coord_t X_VIS_END = coord_t'(H_VIS);
  localparam coord_t Y_VIS_END = coord_t'(V_VIS);

  localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);
  localparam logic [1:0] DIV_HALF = 2'(PIX_DIV / 2);

  // Elaboration-time parameter legality
  if (PIX_DIV < 1 || PIX_DIV > 4) begin : g_chk_div
    $error("vga_timing_gen: PIX_DIV=%0d outside 1..4", PIX_DIV);
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 3) begin : g_chk_dly
    $error("vga_timing_gen: PIPE_DLY=%0d outside 0..3", PIPE_DLY);
  end
  if (!fits_coord(LINE_LEN) || !fits_coord(FRAME_LINES)) begin : g_chk_raster
    $error("vga_timing_gen: raster %0dx%0d does not fit the coordinate width",
           LINE_LEN, FRAME_LINES);
  end
  if (H_SYNC < 1 || V_SYNC < 1 || H_VIS < 1 || V_VIS < 1) begin : g_chk_region
    $error("vga_timing_gen: visible and sync regions must be non-empty");
  end

  logic [1:0] div_cnt;
  logic [1:0] div_nxt;
  logic       clk_nxt;
  logic       pix_en_q;
  logic       vga_clk_q;
  coord_t     draw_x;
  coord_t     draw_y;
  sync_t      raw;
  sync_t      dly;

  // Next divider count, wrapping after PIX_DIV-1
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 2'd1;
  end

  // Pixel clock level for the next count; with no division it follows pix_en
  if (PIX_DIV == 1) begin : g_clk_nodiv
    always_comb clk_nxt = 1'b1;
  end else begin : g_clk_div
    always_comb clk_nxt = (div_nxt >= DIV_HALF);
  end

  // Divider with registered strobes decoded from the count being entered,
  // so pix_en/VGA_CLK are glitch-free and hold 0 through reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt   <= '0;
      pix_en_q  <= 1'b0;
      vga_clk_q <= 1'b0;
    end else begin
      div_cnt   <= div_nxt;
      pix_en_q  <= (div_nxt == DIV_LAST);
      vga_clk_q <= clk_nxt;
    end
  end

  // Raster counters advance once per pixel tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      draw_x <= '0;
      draw_y <= '0;
    end else if (pix_en_q) begin
      if (draw_x == X_LAST) begin
        draw_x <= '0;
        draw_y <= (draw_y == Y_LAST) ? '0 : draw_y + coord_t'(1);
      end else begin
        draw_x <= draw_x + coord_t'(1);
      end
    end
  end

  // Raw strobes for the current raster position
  always_comb begin
    raw         = SYNC_IDLE;
    raw.hs      = !((draw_x >= X_HS_LO) && (draw_x <= X_HS_HI));
    raw.vs      = !((draw_y >= Y_VS_LO) && (draw_y <= Y_VS_HI));
    raw.blank_n = (draw_x < X_VIS_END) && (draw_y < Y_VIS_END);
    raw.fs      = (draw_x == '0) && (draw_y == '0);
  end

  // The output register and PIPE_DLY alignment stages form one chain of
  // PIPE_DLY+1 pix_en-enabled stages.
  vga_sync_delay #(
    .WIDTH   ($bits(sync_t)),
    .DEPTH   (PIPE_DLY + 1),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (Clk),
    .rst_n (Reset_n),
    .en    (pix_en_q),
    .d     (raw),
    .q     (dly)
  );

  assign DrawX       = draw_x;
  assign DrawY       = draw_y;
  assign pix_en      = pix_en_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = dly.hs;
  assign VGA_VS      = dly.vs;
  assign VGA_BLANK_N = dly.blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign frame_start = dly.fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: eight instances (default, a PIX_DIV x PIPE_DLY
// sweep, and a short-frame variant) checked against an edge-count reference model.
module tb_vga_timing_gen;

  localparam int NI = 8;
  localparam int HT = 800;

  function automatic int pdiv_of(input int i);
    case (i)
      1, 2:    return 1;
      5, 6:    return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int pdly_of(input int i);
    case (i)
      1, 3, 5: return 0;
      2, 4, 6: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int vvis_of(input int i);
    return (i == 7) ? 4 : 480;
  endfunction
  function automatic int vfp_of(input int i);
    return (i == 7) ? 2 : 10;
  endfunction
  function automatic int vbp_of(input int i);
    return (i == 7) ? 2 : 33;
  endfunction
  function automatic int vtot_of(input int i);
    return vvis_of(i) + vfp_of(i) + 2 + vbp_of(i);
  endfunction

  logic       clk;
  logic       rst_n;
  logic [9:0] drawx [NI];
  logic [9:0] drawy [NI];
  logic       pix_en [NI];
  logic       vga_clk [NI];
  logic       hs [NI];
  logic       vs [NI];
  logic       blank_n [NI];
  logic       sync_n [NI];
  logic       fs [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_timing_gen #(
      .PIX_DIV  (pdiv_of(g)),
      .PIPE_DLY (pdly_of(g)),
      .V_VIS    (vvis_of(g)),
      .V_FP     (vfp_of(g)),
      .V_SYNC   (2),
      .V_BP     (vbp_of(g))
    ) u_dut (
      .Clk         (clk),
      .Reset_n     (rst_n),
      .DrawX       (drawx[g]),
      .DrawY       (drawy[g]),
      .pix_en      (pix_en[g]),
      .VGA_CLK     (vga_clk[g]),
      .VGA_HS      (hs[g]),
      .VGA_VS      (vs[g]),
      .VGA_BLANK_N (blank_n[g]),
      .VGA_SYNC_N  (sync_n[g]),
      .frame_start (fs[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Clk edges since reset release
  int m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= 0;
    else        m <= m + 1;
  end

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       pe;
    logic       vclk;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       fs;
    logic       syn;
  } obs_t;

  // Reference: everything follows from the number of Clk edges since release.
  // pix_en is seen high before edge k when k-1 >= 1 and (k-1) mod P == P-1.
  function automatic int ticks_of(input int i, input int mm);
    int p;
    p = pdiv_of(i);
    if (mm <= 0) return 0;
    if (p == 1) return mm - 1;
    return mm / p;
  endfunction

  function automatic obs_t model(input int i, input int mm);
    obs_t e;
    int p, d, t, td, xx, yy, vt, vsl;
    p   = pdiv_of(i);
    d   = pdly_of(i);
    vt  = vtot_of(i);
    vsl = vvis_of(i) + vfp_of(i);
    t   = ticks_of(i, mm);
    e.x    = 10'(t % HT);
    e.y    = 10'((t / HT) % vt);
    e.pe   = (mm >= 1) && ((mm % p) == p - 1);
    e.vclk = (mm >= 1) && ((mm % p) >= p / 2);
    e.syn  = 1'b0;
    if (t >= d + 1) begin
      td   = t - d - 1;
      xx   = td % HT;
      yy   = (td / HT) % vt;
      e.hs = !(xx >= 656 && xx <= 751);
      e.vs = !(yy >= vsl && yy <= vsl + 1);
      e.bl = (xx < 640) && (yy < vvis_of(i));
      e.fs = (xx == 0) && (yy == 0);
    end else begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.bl = 1'b0;
      e.fs = 1'b0;
    end
    return e;
  endfunction

  function automatic obs_t observe(input int i);
    obs_t o;
    o.x    = drawx[i];
    o.y    = drawy[i];
    o.pe   = pix_en[i];
    o.vclk = vga_clk[i];
    o.hs   = hs[i];
    o.vs   = vs[i];
    o.bl   = blank_n[i];
    o.fs   = fs[i];
    o.syn  = sync_n[i];
    return o;
  endfunction

  task automatic check_all(input string tag, input int mm);
    obs_t o, e;
    for (int i = 0; i < NI; i++) begin
      o = observe(i);
      e = model(i, mm);
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s dut%0d m=%0d observed x=%0d y=%0d pe/clk/hs/vs/bl/fs/sync=%b%b%b%b%b%b%b expected x=%0d y=%0d %b%b%b%b%b%b%b",
               tag, i, mm, o.x, o.y, o.pe, o.vclk, o.hs, o.vs, o.bl, o.fs, o.syn,
               e.x, e.y, e.pe, e.vclk, e.hs, e.vs, e.bl, e.fs, e.syn);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Measurement monitor (tick-indexed events per instance)
  logic       mon_on;
  logic [9:0] px [NI];
  logic       phs [NI], pvs [NI], pfs [NI], pbl [NI];
  int tk [NI], ck [NI], x656 [NI], hsf [NI], hsr [NI], w1 [NI], w2 [NI];
  int yvs [NI], vsf [NI], vsr [NI], fs1 [NI], fs2 [NI], fsw [NI];
  int blc [NI], bl1 [NI], bl2 [NI], rc [NI], rc1 [NI], rc2 [NI];
  int run [NI], rmin [NI], rmax [NI];
  logic tick, fsr;
  int   nt;

  // Record first occurrences of line/frame events in pixel ticks and Clk counts
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!mon_on) begin
        px[i] <= '0;  phs[i] <= 1'b1; pvs[i] <= 1'b1; pfs[i] <= 1'b0; pbl[i] <= 1'b0;
        tk[i] <= 0;   ck[i] <= 0;     x656[i] <= -1;  hsf[i] <= -1;   hsr[i] <= -1;
        w1[i] <= -1;  w2[i] <= -1;    yvs[i] <= -1;   vsf[i] <= -1;   vsr[i] <= -1;
        fs1[i] <= -1; fs2[i] <= -1;   fsw[i] <= 0;    blc[i] <= 0;    bl1[i] <= -1;
        bl2[i] <= -1; rc[i] <= 0;     rc1[i] <= -1;   rc2[i] <= -1;   run[i] <= 0;
        rmin[i] <= 99999; rmax[i] <= -1;
      end else begin
        tick = (drawx[i] != px[i]);
        nt   = tk[i] + 1;
        fsr  = fs[i] && !pfs[i];
        px[i]  <= drawx[i];
        phs[i] <= hs[i];
        pvs[i] <= vs[i];
        pfs[i] <= fs[i];
        pbl[i] <= blank_n[i];
        ck[i]  <= ck[i] + 1;
        if (tick) begin
          tk[i] <= nt;
          if (drawx[i] == 10'd656 && x656[i] < 0) x656[i] <= nt;
          if (!hs[i] && phs[i] && hsf[i] < 0) hsf[i] <= nt;
          if (hs[i] && !phs[i] && hsf[i] >= 0 && hsr[i] < 0) hsr[i] <= nt;
          if (drawx[i] == 10'd0) begin
            if (w1[i] < 0)      w1[i] <= ck[i];
            else if (w2[i] < 0) w2[i] <= ck[i];
          end
          if (drawx[i] == 10'd0 && int'(drawy[i]) == vvis_of(i) + vfp_of(i) && yvs[i] < 0)
            yvs[i] <= nt;
          if (!vs[i] && pvs[i] && vsf[i] < 0) vsf[i] <= nt;
          if (vs[i] && !pvs[i] && vsf[i] >= 0 && vsr[i] < 0) vsr[i] <= nt;
          if (fsr) begin
            if (fs1[i] < 0) begin
              fs1[i] <= nt; bl1[i] <= blc[i]; rc1[i] <= rc[i];
            end else if (fs2[i] < 0) begin
              fs2[i] <= nt; bl2[i] <= blc[i]; rc2[i] <= rc[i];
            end
          end
          if (blank_n[i]) begin
            blc[i] <= blc[i] + 1;
            run[i] <= pbl[i] ? run[i] + 1 : 1;
            if (!pbl[i]) rc[i] <= rc[i] + 1;
          end else if (pbl[i]) begin
            rmin[i] <= (run[i] < rmin[i]) ? run[i] : rmin[i];
            rmax[i] <= (run[i] > rmax[i]) ? run[i] : rmax[i];
          end
        end
        if (fs[i] && !(fsr && fs1[i] >= 0) && fs2[i] < 0) fsw[i] <= fsw[i] + 1;
      end
    end
  end

  function automatic bit all_done();
    bit ok;
    ok = (fs2[7] >= 0) && (vsr[7] >= 0) && (rmax[7] >= 0);
    for (int i = 0; i < NI; i++) begin
      ok = ok && (w2[i] >= 0) && (hsr[i] >= 0);
    end
    return ok;
  endfunction

  initial begin
    #(100000 * 20);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int dly;
    rst_n  = 1'b0;
    mon_on = 1'b0;
    done   = 1'b0;

    // Reset held for 5 Clk
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_all("reset", m);
    #2;
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // First ticks of the default instance
    @(negedge clk);
    chk("pix_en_after_clk1", int'(pix_en[0]), 1);
    chk("drawx_after_clk1", int'(drawx[0]), 0);
    check_all("clk1", m);
    @(negedge clk);
    chk("drawx_after_clk2", int'(drawx[0]), 1);
    chk("pix_en_after_clk2", int'(pix_en[0]), 0);
    check_all("clk2", m);

    // Free run with randomly placed full-state checks
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) check_all("run", m);
      done = all_done();
    end
    chk("measure_timeout", int'(done), 1);

    for (int i = 0; i < NI; i++) begin
      chk($sformatf("hs_width[%0d]", i), hsr[i] - hsf[i], 96);
      chk($sformatf("hs_lag[%0d]", i), hsf[i] - x656[i], pdly_of(i) + 1);
      chk($sformatf("line_clk[%0d]", i), w2[i] - w1[i], 800 * pdiv_of(i));
    end
    chk("vs_width", vsr[7] - vsf[7], 2 * HT);
    chk("vs_lag", vsf[7] - yvs[7], pdly_of(7) + 1);
    chk("frame_period", fs2[7] - fs1[7], HT * vtot_of(7));
    chk("fs_width_clk", fsw[7], pdiv_of(7));
    chk("blank_ticks", bl2[7] - bl1[7], 640 * vvis_of(7));
    chk("blank_runs", rc2[7] - rc1[7], vvis_of(7));
    chk("blank_run_min", rmin[7], 640);
    chk("blank_run_max", rmax[7], 640);
    mon_on = 1'b0;

    // Asynchronous reset mid-frame, between Clk edges
    done = 1'b0;
    for (int c = 0; c < 30000 && !done; c++) begin
      @(negedge clk);
      done = (drawx[7] == 10'd300) && (drawy[7] == 10'd3);
    end
    chk("midframe_reached", int'(done), 1);
    dly = int'($urandom_range(1, 5));
    #(dly);
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset_held", m);
    #2;
    rst_n = 1'b1;

    @(negedge clk);
    @(negedge clk);
    chk("restart_x", int'(drawx[7]), 1);
    chk("restart_y", int'(drawy[7]), 0);
    check_all("restart", m);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) check_all("rerun", m);
    end
    check_all("final", m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
